// File: rtl/tcam_arbiter_if.sv
// Requester-side bundle for tcam_arbiter: per-requester commands in, one-hot accept/response out.
interface tcam_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_opcode;
  logic [NUM_REQ-1:0]            req_clr;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_word;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_mask;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic                          rsp_hit;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_opcode, req_clr, req_word, req_mask, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_hit, rsp_data
  );

  modport slave (
    input  req_valid, req_opcode, req_clr, req_word, req_mask, req_addr, req_data,
    output req_ready, rsp_valid, rsp_hit, rsp_data
  );
endinterface

// File: rtl/tcam_arbiter.sv
// Shares one tcam between NUM_REQ requesters; round-robin by default, strict lowest-index
// priority when TCAM_ARB_FIXED_PRIO_EN is defined. One command outstanding at a time.
module tcam_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WORD_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tcam_arbiter_if.slave         req_bus,
  output logic                  tcam_req,
  output logic                  tcam_opcode,
  output logic                  tcam_clr,
  output logic [WORD_WIDTH-1:0] tcam_word,
  output logic [WORD_WIDTH-1:0] tcam_mask,
  output logic [ADDR_WIDTH-1:0] tcam_addr,
  output logic [DATA_WIDTH-1:0] tcam_data,
  output logic                  tcam_ack,
  input  logic                  tcam_valid,
  input  logic [DATA_WIDTH-1:0] tcam_data_out,
  output logic                  busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cnt;
`ifndef TCAM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] ptr;
`endif

  // Scan from the highest candidate down so the closest requester to the start point wins.
  always_comb begin
    pick = '0;
    idx  = '0;
`ifdef TCAM_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDX_W'(i);
      if (req_bus.req_valid[idx]) pick = idx;
    end
`else
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req_bus.req_valid[idx]) pick = idx;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      win               <= '0;
      cnt               <= '0;
`ifndef TCAM_ARB_FIXED_PRIO_EN
      ptr               <= '0;
`endif
      tcam_req          <= 1'b0;
      tcam_opcode       <= 1'b0;
      tcam_clr          <= 1'b0;
      tcam_word         <= '0;
      tcam_mask         <= '0;
      tcam_addr         <= '0;
      tcam_data         <= '0;
      tcam_ack          <= 1'b0;
      busy              <= 1'b0;
      req_bus.req_ready <= '0;
      req_bus.rsp_valid <= '0;
      req_bus.rsp_hit   <= 1'b0;
      req_bus.rsp_data  <= '0;
    end else begin
      tcam_req          <= 1'b0;
      tcam_ack          <= 1'b0;
      req_bus.req_ready <= '0;
      req_bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (|req_bus.req_valid) begin
            win                     <= pick;
            tcam_opcode             <= req_bus.req_opcode[pick];
            tcam_clr                <= req_bus.req_clr[pick];
            tcam_word               <= WORD_WIDTH'(req_bus.req_word >> (int'(pick) * WORD_WIDTH));
            tcam_mask               <= WORD_WIDTH'(req_bus.req_mask >> (int'(pick) * WORD_WIDTH));
            tcam_addr               <= ADDR_WIDTH'(req_bus.req_addr >> (int'(pick) * ADDR_WIDTH));
            tcam_data               <= DATA_WIDTH'(req_bus.req_data >> (int'(pick) * DATA_WIDTH));
            tcam_req                <= 1'b1;
            req_bus.req_ready[pick] <= 1'b1;
            busy                    <= 1'b1;
            state                   <= ISSUE;
          end else begin
            busy <= 1'b0;
          end
        end
        ISSUE: begin
          cnt   <= tcam_opcode ? 4'(READ_LATENCY - 1) : 4'(WRITE_LATENCY - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            req_bus.rsp_hit  <= tcam_opcode & tcam_valid;
            req_bus.rsp_data <= (tcam_opcode && tcam_valid) ? tcam_data_out : '0;
            state            <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          req_bus.rsp_valid[win] <= 1'b1;
          tcam_ack               <= 1'b1;
`ifndef TCAM_ARB_FIXED_PRIO_EN
          ptr <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
`endif
          // A request already pending will be granted in the very next IDLE, so busy stays up.
          busy  <= |req_bus.req_valid;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcam_arbiter.sv
// Directed self-checking bench for tcam_arbiter with a small latency-accurate tcam model.
module tb_tcam_arbiter;

  localparam logic [31:0] XORK = 32'hB791_A987;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tcam_req, tcam_opcode, tcam_clr, tcam_ack, busy;
  logic [31:0] tcam_word, tcam_mask, tcam_data;
  logic [3:0]  tcam_addr;
  logic        tcam_valid;
  logic [31:0] tcam_data_out;

  logic        model_hit = 1'b1;
  logic [3:0]  mcnt;

  int vectors = 0;
  int miscompares = 0;
  int seen_req, seen_ready, seen_ack;

  tcam_arbiter_if #(.NUM_REQ(4), .WORD_WIDTH(32), .ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  tcam_arbiter #(
    .NUM_REQ(4), .WORD_WIDTH(32), .ADDR_WIDTH(4), .DATA_WIDTH(32),
    .READ_LATENCY(4), .WRITE_LATENCY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_bus(bus),
    .tcam_req(tcam_req), .tcam_opcode(tcam_opcode), .tcam_clr(tcam_clr),
    .tcam_word(tcam_word), .tcam_mask(tcam_mask), .tcam_addr(tcam_addr),
    .tcam_data(tcam_data), .tcam_ack(tcam_ack), .tcam_valid(tcam_valid),
    .tcam_data_out(tcam_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // tcam model: writes complete 1 cycle after req, lookups present valid/data 4 cycles after req.
  // Data is always driven (word ^ XORK) so the arbiter's zeroing on write/miss is observable.
  always @(posedge clk) begin
    if (!rst_n) begin
      mcnt          <= 4'd0;
      tcam_valid    <= 1'b0;
      tcam_data_out <= '0;
    end else if (tcam_req) begin
      tcam_valid    <= tcam_opcode ? 1'b0 : model_hit;
      tcam_data_out <= tcam_opcode ? 32'h0 : (tcam_word ^ XORK);
      mcnt          <= tcam_opcode ? 4'd1 : 4'd0;
    end else if (mcnt != 4'd0) begin
      mcnt <= (mcnt == 4'd3) ? 4'd0 : mcnt + 4'd1;
      if (mcnt == 4'd3) begin
        tcam_valid    <= model_hit;
        tcam_data_out <= tcam_word ^ XORK;
      end
    end
  end

  task automatic clear_reqs();
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_clr    = '0;
    bus.req_word   = '0;
    bus.req_mask   = '0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
  endtask

  task automatic set_req(input int i, input logic op, input logic clr, input logic [31:0] word,
                         input logic [31:0] mask, input logic [3:0] addr, input logic [31:0] data);
    bus.req_opcode[i]        = op;
    bus.req_clr[i]           = clr;
    bus.req_word[i*32 +: 32] = word;
    bus.req_mask[i*32 +: 32] = mask;
    bus.req_addr[i*4 +: 4]   = addr;
    bus.req_data[i*32 +: 32] = data;
  endtask

  // Advance to the first negedge where tcam_req is high (bounded); caller checks the outcome.
  task automatic wait_tcam_req();
    int n;
    n = 0;
    @(negedge clk);
    while (tcam_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // From a tcam_req cycle, count cycles until rsp_valid appears (bounded) and tally side pulses.
  task automatic wait_rsp(output int k);
    k = 0;
    seen_req = 0; seen_ready = 0; seen_ack = 0;
    do begin
      @(negedge clk);
      k++;
      if (tcam_req === 1'b1) seen_req++;
      if (bus.req_ready !== 4'b0000) seen_ready++;
      if (tcam_ack === 1'b1) seen_ack++;
    end while (bus.rsp_valid === 4'b0000 && k < 40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_reqs();
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++;
    if (tcam_req !== 1'b0 || tcam_ack !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_tcam: got req=%b ack=%b expected 0/0", tcam_req, tcam_ack);
    end
    vectors++;
    if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_handshake: got ready=%b rsp=%b expected 0000/0000", bus.req_ready, bus.rsp_valid);
    end
    vectors++;
    if (bus.rsp_hit !== 1'b0 || bus.rsp_data !== 32'h0 || tcam_word !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_regs: got hit=%b data=%h word=%h expected 0", bus.rsp_hit, bus.rsp_data, tcam_word);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    int k;
    model_hit = 1'b1;
    set_req(0, 1'b0, 1'b1, 32'hA5A5_0000, 32'hFFFF_0000, 4'd3, 32'h1234_5678);
    bus.req_valid = 4'b0001;
    wait_tcam_req();
    vectors++;
    if (tcam_req !== 1'b1) begin miscompares++; $display("[TB] FAIL write_issue: got tcam_req=%b expected 1", tcam_req); end
    bus.req_valid = 4'b0000;
    vectors++;
    if (bus.req_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL write_ready: got %b expected 0001", bus.req_ready); end
    vectors++;
    if (tcam_opcode !== 1'b0 || tcam_clr !== 1'b1 || tcam_addr !== 4'd3) begin
      miscompares++;
      $display("[TB] FAIL write_ctrl: got op=%b clr=%b addr=%0d expected 0/1/3", tcam_opcode, tcam_clr, tcam_addr);
    end
    vectors++;
    if (tcam_word !== 32'hA5A5_0000 || tcam_mask !== 32'hFFFF_0000 || tcam_data !== 32'h1234_5678) begin
      miscompares++;
      $display("[TB] FAIL write_fields: got word=%h mask=%h data=%h expected a5a50000/ffff0000/12345678",
               tcam_word, tcam_mask, tcam_data);
    end
    wait_rsp(k);
    vectors++;
    if (k != 3) begin miscompares++; $display("[TB] FAIL write_latency: got %0d cycles expected 3", k); end
    vectors++;
    if (seen_req != 0 || seen_ready != 0) begin
      miscompares++; $display("[TB] FAIL write_single_pulse: got extra req=%0d ready=%0d expected 0/0", seen_req, seen_ready);
    end
    vectors++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_hit !== 1'b0 || bus.rsp_data !== 32'h0 || tcam_ack !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL write_rsp: got rsp=%b hit=%b data=%h ack=%b expected 0001/0/00000000/1",
               bus.rsp_valid, bus.rsp_hit, bus.rsp_data, tcam_ack);
    end
    @(negedge clk);
    vectors++;
    if (bus.rsp_valid !== 4'b0000 || tcam_ack !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL write_after: got rsp=%b ack=%b busy=%b expected 0000/0/0", bus.rsp_valid, tcam_ack, busy);
    end
  endtask

  task automatic test_lookup_hit();
    int k;
    model_hit = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'hA5A5_FFFF, 32'hFFFF_FFFF, 4'd0, 32'h0);
    bus.req_valid = 4'b0001;
    wait_tcam_req();
    bus.req_valid = 4'b0000;
    vectors++;
    if (tcam_req !== 1'b1 || tcam_opcode !== 1'b1 || tcam_word !== 32'hA5A5_FFFF) begin
      miscompares++;
      $display("[TB] FAIL hit_issue: got req=%b op=%b word=%h expected 1/1/a5a5ffff", tcam_req, tcam_opcode, tcam_word);
    end
    wait_rsp(k);
    vectors++;
    if (k != 6) begin miscompares++; $display("[TB] FAIL hit_latency: got %0d cycles expected 6", k); end
    vectors++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_hit !== 1'b1 || bus.rsp_data !== 32'h1234_5678) begin
      miscompares++;
      $display("[TB] FAIL hit_rsp: got rsp=%b hit=%b data=%h expected 0001/1/12345678",
               bus.rsp_valid, bus.rsp_hit, bus.rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_lookup_miss();
    int k;
    int acks;
    model_hit = 1'b0;
    set_req(1, 1'b1, 1'b0, 32'h0BAD_0BAD, 32'hFFFF_FFFF, 4'd5, 32'h0);
    bus.req_valid = 4'b0010;
    wait_tcam_req();
    bus.req_valid = 4'b0000;
    wait_rsp(k);
    acks = seen_ack;
    vectors++;
    if (bus.rsp_valid !== 4'b0010 || bus.rsp_hit !== 1'b0 || bus.rsp_data !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL miss_rsp: got rsp=%b hit=%b data=%h expected 0010/0/00000000",
               bus.rsp_valid, bus.rsp_hit, bus.rsp_data);
    end
    repeat (3) begin
      @(negedge clk);
      if (tcam_ack === 1'b1) acks++;
    end
    vectors++;
    if (acks != 1) begin miscompares++; $display("[TB] FAIL miss_ack_count: got %0d expected 1", acks); end
    model_hit = 1'b1;
  endtask

  task automatic test_back_to_back();
    int grants[5];
    int rsp_idx[5];
    logic [31:0] rsp_dat[5];
    logic rsp_ht[5];
    int g, r, drops, cyc;
    logic started;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_hit = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 32'hC0DE_0000 | i, 32'hFFFF_FFFF, 4'(i), 32'h0);
    bus.req_valid = 4'b1111;
    g = 0; r = 0; drops = 0; cyc = 0; started = 1'b0;
    while (r < 5 && cyc < 150) begin
      @(negedge clk);
      cyc++;
      if (tcam_req === 1'b1) started = 1'b1;
      if (started && busy !== 1'b1) drops++;
      if (bus.req_ready !== 4'b0000 && g < 5) begin
        for (int b = 3; b >= 0; b--) if (bus.req_ready[b]) grants[g] = b;
        g++;
      end
      if (bus.rsp_valid !== 4'b0000) begin
        for (int b = 3; b >= 0; b--) if (bus.rsp_valid[b]) rsp_idx[r] = b;
        rsp_dat[r] = bus.rsp_data;
        rsp_ht[r]  = bus.rsp_hit;
        r++;
        if (r == 5) bus.req_valid = 4'b0000;
      end
    end
    vectors++;
    if (r != 5) begin miscompares++; $display("[TB] FAIL rr_timeout: got %0d responses expected 5", r); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (i < g && grants[i] != i % 4) begin
        miscompares++; $display("[TB] FAIL rr_grant%0d: got %0d expected %0d", i, grants[i], i % 4);
      end
      vectors++;
      if (i < r && (rsp_idx[i] != i % 4 || rsp_ht[i] !== 1'b1 || rsp_dat[i] !== ((32'hC0DE_0000 | (i % 4)) ^ XORK))) begin
        miscompares++;
        $display("[TB] FAIL rr_rsp%0d: got idx=%0d hit=%b data=%h expected %0d/1/%h",
                 i, rsp_idx[i], rsp_ht[i], rsp_dat[i], i % 4, (32'hC0DE_0000 | (i % 4)) ^ XORK);
      end
    end
    vectors++;
    if (drops != 0) begin miscompares++; $display("[TB] FAIL rr_busy: got %0d idle cycles expected 0", drops); end
    clear_reqs();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int k;
    int stray;
    // Serve requester 2 so that the pointer is left at 3.
    set_req(2, 1'b1, 1'b0, 32'h2222_0000, 32'hFFFF_FFFF, 4'd2, 32'h0);
    bus.req_valid = 4'b0100;
    wait_tcam_req();
    bus.req_valid = 4'b0000;
    wait_rsp(k);
    vectors++;
    if (bus.rsp_valid !== 4'b0100) begin miscompares++; $display("[TB] FAIL mid_prep_rsp: got %b expected 0100", bus.rsp_valid); end
    set_req(1, 1'b1, 1'b0, 32'h1111_0000, 32'hFFFF_FFFF, 4'd1, 32'h0);
    bus.req_valid = 4'b0010;
    wait_tcam_req();
    bus.req_valid = 4'b0000;
    vectors++;
    if (bus.req_ready !== 4'b0010) begin miscompares++; $display("[TB] FAIL mid_grant: got %b expected 0010", bus.req_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tcam_req !== 1'b0 || bus.rsp_valid !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got busy=%b req=%b rsp=%b expected 0/0/0000", busy, tcam_req, bus.rsp_valid);
    end
    rst_n = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid !== 4'b0000 || busy !== 1'b0) stray++;
    end
    vectors++;
    if (stray != 0) begin miscompares++; $display("[TB] FAIL mid_no_rsp: got %0d active cycles expected 0", stray); end
    set_req(3, 1'b1, 1'b0, 32'h3333_0000, 32'hFFFF_FFFF, 4'd3, 32'h0);
    bus.req_valid = 4'b1100;
    wait_tcam_req();
    bus.req_valid = 4'b0000;
    vectors++;
    if (bus.req_ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL mid_ptr_reset: got %b expected 0100", bus.req_ready); end
    wait_rsp(k);
    vectors++;
    if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== (32'h2222_0000 ^ XORK)) begin
      miscompares++;
      $display("[TB] FAIL mid_after_rsp: got rsp=%b data=%h expected 0100/%h", bus.rsp_valid, bus.rsp_data, 32'h2222_0000 ^ XORK);
    end
    clear_reqs();
    repeat (3) @(negedge clk);
  endtask

`ifdef TCAM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int r, cyc, bad_grant, ready3;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'hF000_0000, 32'hFFFF_FFFF, 4'd0, 32'h0);
    set_req(3, 1'b1, 1'b0, 32'hF000_0003, 32'hFFFF_FFFF, 4'd3, 32'h0);
    bus.req_valid = 4'b1001;
    r = 0; cyc = 0; bad_grant = 0; ready3 = 0;
    while (r < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.req_ready !== 4'b0000 && bus.req_ready !== 4'b0001) bad_grant++;
      if (bus.req_ready[3] === 1'b1) ready3++;
      if (bus.rsp_valid !== 4'b0000) begin
        if (bus.rsp_valid !== 4'b0001) bad_grant++;
        r++;
      end
    end
    bus.req_valid = 4'b0000;
    vectors++;
    if (r != 3) begin miscompares++; $display("[TB] FAIL fixed_timeout: got %0d responses expected 3", r); end
    vectors++;
    if (bad_grant != 0) begin miscompares++; $display("[TB] FAIL fixed_grant: got %0d non-zero grants expected 0", bad_grant); end
    vectors++;
    if (ready3 != 0) begin miscompares++; $display("[TB] FAIL fixed_starve: got %0d ready[3] pulses expected 0", ready3); end
    clear_reqs();
    repeat (8) @(negedge clk);
  endtask
`endif

  initial begin
    clear_reqs();
    $display("[TB] tcam_arbiter bench start");
    test_reset();
    test_write();
    test_lookup_hit();
    test_lookup_miss();
`ifdef TCAM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_back_to_back();
`endif
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
